// File: rtl/fp_pkg.sv
// fp_pkg
// Shared definitions for the fingerprint front end: the row packer that
// binarizes camera rows into the fingerprint RAM and the display/search
// stage that reads them back.
//   ROW_PIX    - pixels per image row, one RAM word
//   ROWS       - rows per frame
//   INIT_THRES - binarization threshold used for the first row of a frame
//   ADDR_W     - width of the fingerprint RAM row address
//   fp_state_t - capture controller states
//   sat_u8     - clamps a signed intermediate into the 0..255 pixel range
package fp_pkg;

  localparam int         ROW_PIX    = 256;
  localparam int         ROWS       = 288;
  localparam logic [7:0] INIT_THRES = 8'd128;
  localparam int         ADDR_W     = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } fp_state_t;

  // Mean plus a signed offset spans -128..382, so ten signed bits are
  // enough to hold it before clamping back into a pixel value.
  function automatic logic [7:0] sat_u8(input logic signed [9:0] v);
    if (v < 10'sd0) begin
      return 8'd0;
    end else if (v > 10'sd255) begin
      return 8'hFF;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/fp_row_packer_if.sv
// fp_row_packer_if
// Groups the pixel stream and the fingerprint RAM write port of the row
// packer.
//   pix_valid/pix_data/pix_ready - grayscale pixel handshake (0 black, 255 white)
//   ram_we/ram_add/ram_data      - one-word write of a packed binary row
// Modports:
//   master - pixel source / RAM side (drives pixels, observes writes)
//   slave  - the row packer (consumes pixels, drives RAM writes)
interface fp_row_packer_if #(
  parameter int ROW_PIX = fp_pkg::ROW_PIX
);

  logic                      pix_valid;
  logic [7:0]                pix_data;
  logic                      pix_ready;
  logic                      ram_we;
  logic [fp_pkg::ADDR_W-1:0] ram_add;
  logic [ROW_PIX-1:0]        ram_data;

  modport master (
    output pix_valid,
    output pix_data,
    input  pix_ready,
    input  ram_we,
    input  ram_add,
    input  ram_data
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    output pix_ready,
    output ram_we,
    output ram_add,
    output ram_data
  );

endinterface

// File: rtl/fp_thres_calc.sv
// fp_thres_calc
// Derives the binarization threshold for the next row from the mean of the
// row just captured, shifted by a signed offset and clamped to 0..255.
//   mean     - upper byte of the 16-bit pixel sum of one row
//   thr_next - threshold to apply to the following row
module fp_thres_calc #(
  parameter logic signed [7:0] THRES_OFS = 8'sd0
) (
  input  logic [7:0] mean,
  output logic [7:0] thr_next
);
  import fp_pkg::*;

  logic signed [9:0] biased;

  // Both operands are widened to ten bits first so that a negative offset
  // on a dark row, or a positive offset on a bright row, cannot wrap.
  always_comb begin
    biased   = $signed({2'b00, mean}) + $signed({{2{THRES_OFS[7]}}, THRES_OFS});
    thr_next = sat_u8(biased);
  end

endmodule

// File: rtl/fp_row_packer.sv
// fp_row_packer
// Captures one grayscale frame, binarizes every pixel against an adaptive
// threshold (ridge = darker than threshold = 1) and writes each packed row
// as a single word into the fingerprint row RAM.
//   fp_clk    - single clock for all logic
//   rst       - synchronous active-high reset, overrides start
//   start     - pulse that begins capture of one frame (ignored while busy)
//   busy      - high while a frame is being captured
//   test_done - one-cycle pulse after the last row has been written
//   bus       - pixel handshake and RAM write port (slave side)
module fp_row_packer #(
  parameter int                ROW_PIX    = fp_pkg::ROW_PIX,
  parameter int                ROWS       = fp_pkg::ROWS,
  parameter logic [7:0]        INIT_THRES = fp_pkg::INIT_THRES,
  parameter logic signed [7:0] THRES_OFS  = 8'sd0
) (
  input  logic          fp_clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          test_done,
  fp_row_packer_if.slave bus
);
  import fp_pkg::*;

  localparam int                COL_W    = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(ROW_PIX - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  fp_state_t          state_q;
  fp_state_t          state_d;
  logic [ADDR_W-1:0]  row_q;
  logic [COL_W-1:0]   col_q;
  logic [15:0]        sum_q;
  logic [7:0]         thr_q;
  logic [7:0]         thr_next;
  logic [ROW_PIX-1:0] word_q;
  logic               pix_ready_c;
  logic               ram_we_c;
  logic               accept;

  assign accept = bus.pix_valid && pix_ready_c;

  fp_thres_calc #(
    .THRES_OFS (THRES_OFS)
  ) u_thres (
    .mean     (sum_q[15:8]),
    .thr_next (thr_next)
  );

  // State register; reset drops any frame in progress back to IDLE.
  always_ff @(posedge fp_clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and control outputs. WRITE lasts exactly one cycle, and DONE
  // always falls through to IDLE so a start coinciding with test_done is
  // dropped rather than launching a new frame.
  always_comb begin
    state_d     = state_q;
    pix_ready_c = 1'b0;
    ram_we_c    = 1'b0;
    busy        = 1'b0;
    test_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
        end
      end
      FILL: begin
        pix_ready_c = 1'b1;
        busy        = 1'b1;
        if (accept && (col_q == LAST_COL)) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        ram_we_c = 1'b1;
        busy     = 1'b1;
        state_d  = (row_q == LAST_ROW) ? DONE : FILL;
      end
      DONE: begin
        test_done = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Row datapath. The row word is cleared whenever FILL is entered so bits
  // not yet captured read as 0. On the final row the counter is held rather
  // than advanced, keeping the RAM address inside the frame.
  always_ff @(posedge fp_clk) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      sum_q  <= '0;
      thr_q  <= INIT_THRES;
      word_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            row_q  <= '0;
            col_q  <= '0;
            sum_q  <= '0;
            thr_q  <= INIT_THRES;
            word_q <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            word_q[col_q] <= (bus.pix_data < thr_q);
            sum_q         <= sum_q + {8'd0, bus.pix_data};
            col_q         <= col_q + 1'b1;
          end
        end
        WRITE: begin
          thr_q <= thr_next;
          sum_q <= '0;
          col_q <= '0;
          if (row_q != LAST_ROW) begin
            row_q  <= row_q + 1'b1;
            word_q <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.pix_ready = pix_ready_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.ram_add   = row_q;
  assign bus.ram_data  = word_q;

endmodule

// File: tb/tb_fp_row_packer.sv
// tb_fp_row_packer
// Self-checking bench for fp_row_packer with full 256-pixel rows and a
// short frame, so that row means and thresholds behave exactly as in the
// full-size design. Expected RAM writes are pushed to a queue as each row is
// driven and popped by a monitor when ram_we is seen.
module tb_fp_row_packer;

  localparam int         TB_ROW_PIX = 256;
  localparam int         TB_ROWS    = 6;
  localparam logic [7:0] TB_INIT    = 8'd128;
  localparam int         TB_OFS     = 0;

  typedef struct {
    logic [8:0]            addr;
    logic [TB_ROW_PIX-1:0] data;
  } wr_t;

  logic fp_clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic test_done;

  wr_t  exp_q[$];
  int   n_checks    = 0;
  int   n_errors    = 0;
  int   writes_seen = 0;
  int   done_seen   = 0;
  logic prev_we     = 1'b0;
  logic prev_done   = 1'b0;

  logic [7:0]            frame_pix [TB_ROWS][TB_ROW_PIX];
  logic [7:0]            rnd_pix   [TB_ROWS][TB_ROW_PIX];
  logic [TB_ROW_PIX-1:0] got_word  [TB_ROWS];
  logic [TB_ROW_PIX-1:0] ref_word  [TB_ROWS];

  always #5 fp_clk = ~fp_clk;

  fp_row_packer_if #(.ROW_PIX(TB_ROW_PIX)) bus ();

  fp_row_packer #(
    .ROW_PIX    (TB_ROW_PIX),
    .ROWS       (TB_ROWS),
    .INIT_THRES (TB_INIT),
    .THRES_OFS  (8'sd0)
  ) dut (
    .fp_clk    (fp_clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .test_done (test_done),
    .bus       (bus)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [TB_ROW_PIX-1:0] actual,
                             input logic [TB_ROW_PIX-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Monitor on the falling edge: pops the scoreboard on every RAM write and
  // checks that write and done strobes never last more than one cycle.
  always @(negedge fp_clk) begin
    wr_t w;
    if (bus.ram_we === 1'b1) begin
      checkOutput("ram_we_width", prev_we, 0);
      checkOutput("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        checkOutput("ram_add", bus.ram_add, w.addr);
        checkOutput("ram_data", bus.ram_data, w.data);
      end
      if (bus.ram_add < TB_ROWS) begin
        got_word[bus.ram_add] = bus.ram_data;
      end
      writes_seen++;
    end
    if (test_done === 1'b1) begin
      checkOutput("test_done_width", prev_done, 0);
      checkOutput("busy_low_at_done", busy, 0);
      done_seen++;
    end
    prev_we   = bus.ram_we;
    prev_done = test_done;
  end

  // Builds the pixel frame for a scenario.
  task automatic fillFrame(input int kind);
    for (int r = 0; r < TB_ROWS; r++) begin
      for (int c = 0; c < TB_ROW_PIX; c++) begin
        case (kind)
          0: frame_pix[r][c] = 8'h40;
          1: frame_pix[r][c] = (r == 0) ? 8'h90 : (r == 1) ? 8'h70 : rnd_pix[r][c];
          2: begin
            if (r == 0) begin
              frame_pix[r][c] = (c % 2 == 0) ? 8'h00 : 8'hFF;
            end else if (r == 1) begin
              frame_pix[r][c] = (c % 2 == 0) ? 8'h7E : 8'h7F;
            end else begin
              frame_pix[r][c] = rnd_pix[r][c];
            end
          end
          default: frame_pix[r][c] = rnd_pix[r][c];
        endcase
      end
    end
  endtask

  // Offers one pixel until the handshake completes; duty < 100 inserts
  // random idle cycles before the pixel.
  task automatic sendPixel(input logic [7:0] d, input int duty);
    int guard;
    guard = 0;
    if (duty < 100) begin
      while (($urandom_range(99, 0) >= duty) && (guard < 50)) begin
        bus.pix_valid = 1'b0;
        @(posedge fp_clk);
        #1;
        guard++;
      end
    end
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    guard = 0;
    while ((bus.pix_ready !== 1'b1) && (guard < 200)) begin
      @(posedge fp_clk);
      #1;
      guard++;
    end
    if (guard >= 200) begin
      checkOutput("pix_ready_timeout", bus.pix_ready, 1);
    end else begin
      @(posedge fp_clk);
      #1;
    end
    bus.pix_valid = 1'b0;
  endtask

  // Waits a bounded time for test_done, then confirms the block went idle.
  // With hold_start the start line stays high through the DONE cycle.
  task automatic waitDone(input bit hold_start);
    int g;
    g = 0;
    while ((test_done !== 1'b1) && (g < 40)) begin
      @(posedge fp_clk);
      #1;
      g++;
    end
    checkOutput("test_done_seen", test_done, 1);
    @(posedge fp_clk);
    #1;
    start = 1'b0;
    checkOutput("idle_after_done_busy", busy, 0);
    checkOutput("idle_after_done_ready", bus.pix_ready, 0);
    if (hold_start) begin
      repeat (20) @(posedge fp_clk);
      #1;
      checkOutput("start_ignored_busy", busy, 0);
    end
  endtask

  // Drives one frame and pushes the expected write for each row before it
  // is sent. abort_row >= 0 resets the block partway through that row.
  task automatic applyStimulus(input int kind, input int duty, input int abort_row,
                               input bit hold_start);
    int                    thr;
    int                    wb;
    int                    db;
    logic [15:0]           sum;
    logic [TB_ROW_PIX-1:0] word;
    wr_t                   w;
    fillFrame(kind);
    for (int r = 0; r < TB_ROWS; r++) begin
      got_word[r] = 'x;
    end
    start = 1'b1;
    @(posedge fp_clk);
    #1;
    if (!hold_start) begin
      start = 1'b0;
    end
    checkOutput("fill_entry_ready", bus.pix_ready, 1);
    checkOutput("fill_entry_busy", busy, 1);
    checkOutput("fill_entry_data_clear", bus.ram_data, 0);
    thr = int'(TB_INIT);
    for (int r = 0; r < TB_ROWS; r++) begin
      sum  = '0;
      word = '0;
      for (int c = 0; c < TB_ROW_PIX; c++) begin
        word[c] = (int'(frame_pix[r][c]) < thr);
        sum     = sum + 16'(frame_pix[r][c]);
      end
      if (r == abort_row) begin
        for (int c = 0; c < 100; c++) begin
          sendPixel(frame_pix[r][c], duty);
        end
        rst = 1'b1;
        @(posedge fp_clk);
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ready", bus.pix_ready, 0);
        checkOutput("abort_ram_we", bus.ram_we, 0);
        checkOutput("abort_ram_add", bus.ram_add, 0);
        checkOutput("abort_ram_data", bus.ram_data, 0);
        checkOutput("abort_test_done", test_done, 0);
        rst = 1'b0;
        wb  = writes_seen;
        db  = done_seen;
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'h40;
        repeat (40) @(posedge fp_clk);
        #1;
        bus.pix_valid = 1'b0;
        checkOutput("abort_no_writes", writes_seen, wb);
        checkOutput("abort_no_done", done_seen, db);
        checkOutput("abort_idle_busy", busy, 0);
        return;
      end
      w.addr = 9'(r);
      w.data = word;
      exp_q.push_back(w);
      for (int c = 0; c < TB_ROW_PIX; c++) begin
        sendPixel(frame_pix[r][c], duty);
      end
      thr = int'(sum[15:8]) + TB_OFS;
      if (thr < 0)   thr = 0;
      if (thr > 255) thr = 255;
    end
    waitDone(hold_start);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'h00;
    for (int r = 0; r < TB_ROWS; r++) begin
      for (int c = 0; c < TB_ROW_PIX; c++) begin
        rnd_pix[r][c] = 8'($urandom_range(255, 0));
      end
    end

    // Reset held together with start: reset must win.
    repeat (3) @(posedge fp_clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ready", bus.pix_ready, 0);
    checkOutput("reset_ram_we", bus.ram_we, 0);
    checkOutput("reset_ram_add", bus.ram_add, 0);
    checkOutput("reset_ram_data", bus.ram_data, 0);
    checkOutput("reset_test_done", test_done, 0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge fp_clk);
    #1;

    // Flat 0x40 frame: row 0 is all ridge; from row 1 the threshold equals
    // the pixel value itself, which is not strictly below it.
    applyStimulus(0, 100, -1, 0);
    checkOutput("flat_row0", got_word[0], {TB_ROW_PIX{1'b1}});
    checkOutput("flat_last_row", got_word[TB_ROWS-1], {TB_ROW_PIX{1'b0}});

    // 0x90 row then 0x70 row.
    applyStimulus(1, 100, -1, 0);
    checkOutput("row0_0x90", got_word[0], {TB_ROW_PIX{1'b0}});
    checkOutput("row1_0x70", got_word[1], {TB_ROW_PIX{1'b1}});

    // Alternating black/white row, then 0x7E/0x7F against threshold 0x7F.
    applyStimulus(2, 100, -1, 0);
    checkOutput("row0_alternating", got_word[0], {(TB_ROW_PIX/4){4'h5}});
    checkOutput("row1_thr_7f", got_word[1], {(TB_ROW_PIX/4){4'h5}});

    // Same random frame with and without valid gaps.
    applyStimulus(3, 100, -1, 0);
    for (int r = 0; r < TB_ROWS; r++) begin
      ref_word[r] = got_word[r];
    end
    applyStimulus(3, 30, -1, 0);
    for (int r = 0; r < TB_ROWS; r++) begin
      checkOutput("gapped_vs_gapfree", got_word[r], ref_word[r]);
    end

    // Reset in the middle of row 3, then a clean restart from address 0.
    applyStimulus(0, 100, 3, 0);
    applyStimulus(0, 100, -1, 0);

    // Start held high through the frame and the DONE cycle.
    applyStimulus(1, 100, -1, 1);

    checkOutput("writes_total", writes_seen, 7 * TB_ROWS + 3);
    checkOutput("done_total", done_seen, 7);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
